// File: rtl/fib_readback_checker.sv
// fib_readback_checker
//
// Read-only companion to the Fibonacci fill sequencer. Drives the
// RegFile_Alu command port with write enable held low, walks registers
// 0..LAST_REG in order, and compares each readback against an internally
// generated Fibonacci value. The scan stops at the first mismatch.
//
// Ports
//   Clk          clock, rising edge
//   Rst          asynchronous active-low reset
//   Start        begin a scan (honoured only when no scan is in progress)
//   RdestOut_i   register-file read data, valid READ_LAT cycles after address
//   RdestRegLoc  register address being read
//   RsrcRegLoc   mirror of RdestRegLoc
//   En           register-file write enable, always 0
//   Imm, Imm_s   immediate operand, always 0
//   OpCode       ALU opcode, always ADD (0)
//   Busy         scan in progress
//   Done         scan finished; held until next accepted Start or reset
//   Pass         all registers matched (meaningful while Done)
//   FailIdx      first mismatching index (0 on pass)
//   Expected     golden value at the last compared index
//   Observed     sampled read data at the last compared index
module fib_readback_checker #(
  parameter int LAST_REG = 15,
  parameter int READ_LAT = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [15:0] RdestOut_i,
  output logic [3:0]  RdestRegLoc,
  output logic [3:0]  RsrcRegLoc,
  output logic        En,
  output logic [15:0] Imm,
  output logic        Imm_s,
  output logic [3:0]  OpCode,
  output logic        Busy,
  output logic        Done,
  output logic        Pass,
  output logic [3:0]  FailIdx,
  output logic [15:0] Expected,
  output logic [15:0] Observed
);

  localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);
  localparam logic [3:0] LAST   = 4'(LAST_REG);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CMP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state, state_n;

  // scan datapath
  logic [3:0]  idx,  idx_n;
  logic [15:0] fa,   fa_n;     // golden fib(idx)
  logic [15:0] fb,   fb_n;     // golden fib(idx+1)
  logic [2:0]  cnt,  cnt_n;    // read-latency countdown
  logic [3:0]  addr_n;
  logic        busy_n, done_n, pass_n;
  logic [3:0]  fail_n;
  logic [15:0] exp_n, obs_n;

  logic        mismatch;
  assign mismatch = (Observed != Expected);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // ---------------------------------------------------------------------
  // Next-state logic; undefined encodings fall back to IDLE
  // ---------------------------------------------------------------------
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (Start) state_n = S_ISSUE;
      S_ISSUE: state_n = S_WAIT;
      S_WAIT:  if (cnt == 3'd0) state_n = S_CMP;
      S_CMP: begin
        if (mismatch || idx == LAST) state_n = S_DONE;
        else                         state_n = S_ISSUE;
      end
      S_DONE:  if (Start) state_n = S_ISSUE;
      default: state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Next values of the registered outputs and datapath
  // ---------------------------------------------------------------------
  always_comb begin
    idx_n  = idx;
    fa_n   = fa;
    fb_n   = fb;
    cnt_n  = cnt;
    addr_n = RdestRegLoc;
    busy_n = Busy;
    done_n = Done;
    pass_n = Pass;
    fail_n = FailIdx;
    exp_n  = Expected;
    obs_n  = Observed;
    case (state)
      S_IDLE, S_DONE: begin
        // Restart from either resting state. FailIdx/Expected/Observed keep
        // the previous result until the new scan overwrites them.
        if (Start) begin
          idx_n  = 4'd0;
          fa_n   = 16'd0;
          fb_n   = 16'd1;
          addr_n = 4'd0;
          busy_n = 1'b1;
          done_n = 1'b0;
          pass_n = 1'b0;
        end
      end
      S_ISSUE: cnt_n = LAT_M1;
      S_WAIT: begin
        if (cnt == 3'd0) begin
          obs_n = RdestOut_i;
          exp_n = fa;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      S_CMP: begin
        if (mismatch) begin
          fail_n = idx;
          pass_n = 1'b0;
          done_n = 1'b1;
          busy_n = 1'b0;
        end else if (idx == LAST) begin
          fail_n = 4'd0;
          pass_n = 1'b1;
          done_n = 1'b1;
          busy_n = 1'b0;
        end else begin
          // idx < LAST <= 15, so idx+1 never wraps
          idx_n  = idx + 4'd1;
          fa_n   = fb;
          fb_n   = fa + fb;
          addr_n = idx + 4'd1;
        end
      end
      default: begin
        // corrupted state: drop any in-flight scan without a result
        busy_n = 1'b0;
        done_n = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output / datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      idx         <= 4'd0;
      fa          <= 16'd0;
      fb          <= 16'd1;
      cnt         <= 3'd0;
      RdestRegLoc <= 4'd0;
      RsrcRegLoc  <= 4'd0;
      En          <= 1'b0;
      Imm         <= 16'd0;
      Imm_s       <= 1'b0;
      OpCode      <= 4'b0000;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Pass        <= 1'b0;
      FailIdx     <= 4'd0;
      Expected    <= 16'd0;
      Observed    <= 16'd0;
    end else begin
      idx         <= idx_n;
      fa          <= fa_n;
      fb          <= fb_n;
      cnt         <= cnt_n;
      RdestRegLoc <= addr_n;
      RsrcRegLoc  <= addr_n;
      // command fields are fixed: read-only ADD with zero immediate
      En          <= 1'b0;
      Imm         <= 16'd0;
      Imm_s       <= 1'b0;
      OpCode      <= 4'b0000;
      Busy        <= busy_n;
      Done        <= done_n;
      Pass        <= pass_n;
      FailIdx     <= fail_n;
      Expected    <= exp_n;
      Observed    <= obs_n;
    end
  end

endmodule

// File: tb/tb_fib_readback_checker.sv
module tb_fib_readback_checker;

  // instance 0: defaults (LAST=15, LAT=1); instance 1: LAST=4, LAT=3
  function automatic int lat_of(input int i);  return (i == 0) ? 1 : 3;  endfunction
  function automatic int last_of(input int i); return (i == 0) ? 15 : 4; endfunction

  function automatic logic [15:0] fib(input int n);
    logic [15:0] a, b, t;
    a = 16'd0; b = 16'd1;
    for (int k = 0; k < n; k++) begin t = a + b; a = b; b = t; end
    return a;
  endfunction

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        start [2];
  logic [15:0] rdata [2];
  logic [3:0]  addr  [2];
  logic [3:0]  rsrc  [2];
  logic        en    [2];
  logic [15:0] imm   [2];
  logic        imms  [2];
  logic [3:0]  opc   [2];
  logic        busy  [2];
  logic        done  [2];
  logic        pass  [2];
  logic [3:0]  fidx  [2];
  logic [15:0] expv  [2];
  logic [15:0] obsv  [2];

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  fib_readback_checker #(.LAST_REG(15), .READ_LAT(1)) dut0 (
    .Clk(Clk), .Rst(Rst), .Start(start[0]), .RdestOut_i(rdata[0]),
    .RdestRegLoc(addr[0]), .RsrcRegLoc(rsrc[0]), .En(en[0]), .Imm(imm[0]),
    .Imm_s(imms[0]), .OpCode(opc[0]), .Busy(busy[0]), .Done(done[0]),
    .Pass(pass[0]), .FailIdx(fidx[0]), .Expected(expv[0]), .Observed(obsv[0]));

  fib_readback_checker #(.LAST_REG(4), .READ_LAT(3)) dut1 (
    .Clk(Clk), .Rst(Rst), .Start(start[1]), .RdestOut_i(rdata[1]),
    .RdestRegLoc(addr[1]), .RsrcRegLoc(rsrc[1]), .En(en[1]), .Imm(imm[1]),
    .Imm_s(imms[1]), .OpCode(opc[1]), .Busy(busy[1]), .Done(done[1]),
    .Pass(pass[1]), .FailIdx(fidx[1]), .Expected(expv[1]), .Observed(obsv[1]));

  // register-file model: data for an address appears READ_LAT cycles later
  logic [15:0] regs [2][16];
  logic [15:0] pipe [2][8];
  always @(posedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 7; j > 0; j--) pipe[i][j] <= pipe[i][j-1];
      pipe[i][0] <= regs[i][addr[i]];
    end
  end
  assign rdata[0] = pipe[0][0];
  assign rdata[1] = pipe[1][2];

  // ---------------------------------------------------------------------
  // Behavioural model: on acceptance, decide the outcome from the register
  // contents, then walk time arithmetically (2+LAT cycles per register).
  // ---------------------------------------------------------------------
  bit          mbusy [2];
  bit          mdone [2];
  bit          mpass [2];
  int          mt    [2];
  int          mlen  [2];
  int          mfin  [2];
  bit          mfails[2];
  logic [15:0] mrd   [2];
  logic [3:0]  maddr [2];
  logic [3:0]  mfail [2];
  logic [15:0] mexp  [2];
  logic [15:0] mobs  [2];

  always @(posedge Clk or negedge Rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!Rst) begin
        mbusy[i] = 0; mdone[i] = 0; mpass[i] = 0; mt[i] = 0;
        maddr[i] = 0; mfail[i] = 0; mexp[i] = 0; mobs[i] = 0;
      end else if (mbusy[i]) begin
        int per, a;
        per = 2 + lat_of(i);
        mt[i]++;
        a = mt[i] / per;
        maddr[i] = 4'((a > mfin[i]) ? mfin[i] : a);
        if (mt[i] == mlen[i]) begin
          mbusy[i] = 0;
          mdone[i] = 1;
          mpass[i] = !mfails[i];
          mfail[i] = mfails[i] ? 4'(mfin[i]) : 4'd0;
          mexp[i]  = fib(mfin[i]);
          mobs[i]  = mrd[i];
        end
      end else if (start[i]) begin
        int k;
        k = -1;
        for (int r = 0; r <= last_of(i); r++)
          if (k < 0 && regs[i][r] != fib(r)) k = r;
        mfails[i] = (k >= 0);
        mfin[i]   = (k >= 0) ? k : last_of(i);
        mlen[i]   = (mfin[i] + 1) * (2 + lat_of(i));
        mrd[i]    = regs[i][mfin[i]];
        mbusy[i] = 1; mdone[i] = 0; mpass[i] = 0; mt[i] = 0; maddr[i] = 0;
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0d want=%0d", nm, i, act, exp);
    end
  endtask

  // compare process: every cycle, away from the clock edge
  always @(negedge Clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("busy",    i, 32'(busy[i]),  32'(mbusy[i]));
      chk("done",    i, 32'(done[i]),  32'(mdone[i]));
      chk("pass",    i, 32'(pass[i]),  32'(mpass[i]));
      chk("failidx", i, 32'(fidx[i]),  32'(mfail[i]));
      chk("addr",    i, 32'(addr[i]),  32'(maddr[i]));
      chk("rsrc",    i, 32'(rsrc[i]),  32'(maddr[i]));
      chk("en",      i, 32'(en[i]),    32'd0);
      chk("imm",     i, 32'(imm[i]),   32'd0);
      chk("imm_s",   i, 32'(imms[i]),  32'd0);
      chk("opcode",  i, 32'(opc[i]),   32'd0);
      chk("busy_and_done", i, 32'(busy[i] & done[i]), 32'd0);
      if (mdone[i] || !Rst) begin
        chk("expected", i, 32'(expv[i]), 32'(mexp[i]));
        chk("observed", i, 32'(obsv[i]), 32'(mobs[i]));
      end
    end
  end

  // pulse Start for one cycle and count edges until Done; optional stray
  // Start pulses at cycles 5 and 20 of the scan
  task automatic run_scan(input int i, input bit stray, output int n,
                          output int maxa, output int hold2);
    start[i] = 1'b1;
    @(negedge Clk);
    start[i] = 1'b0;
    chk("acc_busy", i, 32'(busy[i]), 32'd1);
    chk("acc_done", i, 32'(done[i]), 32'd0);
    chk("acc_pass", i, 32'(pass[i]), 32'd0);
    n = 0; maxa = 0; hold2 = 0;
    while (!done[i] && n < 400) begin
      if (int'(addr[i]) > maxa) maxa = int'(addr[i]);
      if (addr[i] == 4'd2) hold2++;
      @(negedge Clk);
      n++;
      start[i] = stray && (n == 5 || n == 20);
    end
    start[i] = 1'b0;
    if (n >= 400) chk("scan_timeout", i, 32'(n), 32'd0);
  endtask

  task automatic load_fib(input int i);
    for (int r = 0; r < 16; r++) regs[i][r] = fib(r);
  endtask

  initial begin
    int n, maxa, h2;
    start[0] = 0; start[1] = 0;
    load_fib(0); load_fib(1);

    // model pins
    chk("fib15", 0, 32'(fib(15)), 32'd610);
    chk("fib7",  0, 32'(fib(7)),  32'd13);

    repeat (3) @(negedge Clk);
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_exp",  0, 32'(expv[0]), 32'd0);

    // first Start on the edge right after reset release
    Rst = 1'b1;
    run_scan(0, 0, n, maxa, h2);
    chk("pass_lat", 0, n, 48);
    chk("pass_p",   0, 32'(pass[0]), 32'd1);
    chk("pass_fi",  0, 32'(fidx[0]), 32'd0);
    chk("pass_exp", 0, 32'(expv[0]), 32'd610);
    chk("pass_obs", 0, 32'(obsv[0]), 32'd610);

    // stray Start during a scan
    @(negedge Clk);
    run_scan(0, 1, n, maxa, h2);
    chk("stray_lat", 0, n, 48);
    chk("stray_p",   0, 32'(pass[0]), 32'd1);

    // bad R7
    regs[0][7] = 16'd14;
    @(negedge Clk);
    run_scan(0, 0, n, maxa, h2);
    chk("fail_lat",  0, n, 24);
    chk("fail_p",    0, 32'(pass[0]), 32'd0);
    chk("fail_fi",   0, 32'(fidx[0]), 32'd7);
    chk("fail_exp",  0, 32'(expv[0]), 32'd13);
    chk("fail_obs",  0, 32'(obsv[0]), 32'd14);
    chk("fail_maxa", 0, maxa, 7);

    // corrected model after a fail
    regs[0][7] = 16'd13;
    run_scan(0, 0, n, maxa, h2);
    chk("fix_lat", 0, n, 48);
    chk("fix_p",   0, 32'(pass[0]), 32'd1);
    chk("fix_fi",  0, 32'(fidx[0]), 32'd0);

    // reset mid-scan
    start[0] = 1'b1;
    @(negedge Clk);
    start[0] = 1'b0;
    repeat (9) @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("mid_rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("mid_rst_addr", 0, 32'(addr[0]), 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    run_scan(0, 0, n, maxa, h2);
    chk("post_rst_lat", 0, n, 48);
    chk("post_rst_p",   0, 32'(pass[0]), 32'd1);

    // READ_LAT=3, LAST_REG=4
    run_scan(1, 0, n, maxa, h2);
    chk("lat3_lat",   1, n, 25);
    chk("lat3_p",     1, 32'(pass[1]), 32'd1);
    chk("lat3_hold2", 1, h2, 5);
    chk("lat3_exp",   1, 32'(expv[1]), 32'd3);

    // randomized phase: corrupted contents, random or held-high Start,
    // occasional reset
    for (int it = 0; it < 40; it++) begin
      int i, cyc, mode, rstat, w;
      i = int'($urandom_range(0, 1));
      load_fib(i);
      if ($urandom_range(0, 1) == 1) begin
        int k;
        k = int'($urandom_range(0, last_of(i)));
        regs[i][k] = regs[i][k] ^ 16'($urandom_range(1, 65535));
      end
      if ($urandom_range(0, 3) == 0) begin
        int k2;
        k2 = int'($urandom_range(0, last_of(i)));
        regs[i][k2] = regs[i][k2] ^ 16'($urandom_range(1, 65535));
      end
      mode  = int'($urandom_range(0, 2));
      cyc   = int'($urandom_range(30, 120));
      rstat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, cyc)) : -1;
      for (int c = 0; c < cyc; c++) begin
        start[i] = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (c == rstat) Rst = 1'b0;
        else            Rst = 1'b1;
        @(negedge Clk);
      end
      Rst = 1'b1;
      start[i] = 1'b0;
      w = 0;
      while (busy[i] && w < 300) begin @(negedge Clk); w++; end
      if (w >= 300) chk("rand_timeout", i, 32'(w), 32'd0);
      @(negedge Clk);
    end

    repeat (2) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fib_readback_checker.md
# fib_readback_checker

Read-side companion to the Fibonacci fill sequencer. The fill sequencer writes the Fibonacci sequence into the register file through the RegFile_Alu command port. This block drives the same command port in read-only mode and reads back registers 0..LAST_REG in order. It checks each value against an internally generated golden Fibonacci value and reports pass/fail, the first failing index and the offending data. It connects in place of the fill sequencer, with a mux arbitrating the command port, and is used for board bring-up and self-test.

## Interface
Parameters:
- LAST_REG, 15, highest register index checked; legal range 1..15.
- READ_LAT, 1, cycles from address presentation to valid RdestOut_i; legal range 1..7.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- Start  in  1  begin a scan; sampled only in IDLE or DONE.
- RdestOut_i  in  16  read data from RegFile_Alu RdestOut.
- RdestRegLoc  out  4  register address being read.
- RsrcRegLoc  out  4  always equal to RdestRegLoc.
- En  out  1  register-file write enable; constant 0.
- Imm  out  16  constant 0.
- Imm_s  out  1  constant 0.
- OpCode  out  4  constant 4'b0000 (ADD).
- Busy  out  1  high while a scan is in progress.
- Done  out  1  high from scan completion until the next accepted Start or reset.
- Pass  out  1  valid while Done is high; 1 means all registers matched.
- FailIdx  out  4  index of the first mismatch; 0 when Pass=1.
- Expected  out  16  golden value at the last compared index.
- Observed  out  16  sampled RdestOut_i at the last compared index.

## Operation
- All outputs are registered.
- Reset values: RdestRegLoc=0, RsrcRegLoc=0, En=0, Imm=0, Imm_s=0, OpCode=0, Busy=0, Done=0, Pass=0, FailIdx=0, Expected=0, Observed=0. State=IDLE, idx=0, golden pair (a,b)=(0,1).
- The block never asserts En. It must not alter register-file contents.
- Golden sequence: fib(0)=0, fib(1)=1, fib(n)=fib(n-1)+fib(n-2). Additions are 16-bit modulo 2^16. All values through fib(15)=610 fit without wrap.
- State machine:
  - IDLE: when Start=1, set idx=0, (a,b)=(0,1), RdestRegLoc=0, Busy=1, Done=0, Pass=0. Go to ISSUE.
  - ISSUE: address idx is held on RdestRegLoc/RsrcRegLoc. Load wait counter with READ_LAT-1. Go to WAIT.
  - WAIT: decrement the counter each cycle. On the edge where the counter is 0, latch RdestOut_i into Observed and a into Expected. Go to CMP.
  - CMP, on mismatch (Observed != Expected): FailIdx=idx, Pass=0, Done=1, Busy=0. Go to DONE.
  - CMP, on match with idx==LAST_REG: Pass=1, FailIdx=0, Done=1, Busy=0. Go to DONE.
  - CMP, on match otherwise: idx=idx+1, (a,b)=(b,a+b), RdestRegLoc=idx+1. Go to ISSUE.
  - DONE: hold all results. When Start=1, behave as IDLE with Start=1; Done and Pass clear on that edge.
- The scan stops at the first mismatch; no later register is read.
- Start while Busy=1 is ignored and has no effect on the scan.
- Start held high continuously re-triggers a new scan on the edge after each DONE entry.
- Rst low at any time, including mid-scan, forces all reset values immediately. An interrupted scan is abandoned and produces no partial result.
- An illegal state encoding recovers to IDLE on the next edge.

## Timing
- Each register costs 2+READ_LAT cycles: 1 in ISSUE, READ_LAT in WAIT, 1 in CMP.
- Done and Busy change on the same edge; they are never both high.
- Full-pass latency: Done rises (LAST_REG+1)*(2+READ_LAT) edges after the edge that accepted Start. With defaults this is 48 edges.
- Fail at index k: Done rises (k+1)*(2+READ_LAT) edges after acceptance.
- The address is stable for at least READ_LAT cycles before the sample edge, and does not change until CMP completes.
- After reset deassertion, the first Start can be accepted on the next rising edge.

## Test plan
- Register file model preloaded with fib(0..15), defaults, pulse Start -> Busy high for 48 cycles, then Done=1, Pass=1, FailIdx=0, Expected=610, Observed=610; En is 0 throughout.
- Model with R7=14 (golden 13) -> Done after 24 cycles, Pass=0, FailIdx=7, Expected=13, Observed=14; RdestRegLoc never exceeds 7.
- READ_LAT=3, model delays data 3 cycles, LAST_REG=4 -> Pass=1 after 25 cycles; each address is held for 5 cycles.
- Start pulsed at cycles 5 and 20 of a running scan -> no restart; completion timing is identical to the single-Start case.
- Rst low at cycle 10 of a scan, released, then Start -> all outputs return to reset values immediately; the new scan starts at idx 0 and passes in 48 cycles.
- After a fail result, pulse Start with a corrected model -> Done and Pass clear on the accepting edge; new result is Pass=1.
